// File: rtl/fm_cmn_bfifo_burst_rd.sv
// fm_cmn_bfifo_burst_rd
// Burst drain engine for the consumer side of a first-word-fall-through
// block-RAM FIFO. It waits until a full burst is buffered (or a flush allows a
// partial one), issues one write-burst command, then streams exactly that many
// words from the FIFO head through a single registered data stage.
//
// Ports:
//   clk_core, rst_x      clock, asynchronous active-low reset
//   i_start/i_adrs_base  load the base word address (IDLE only)
//   i_enable             permits new bursts
//   i_flush              permits a partial burst; drives o_flush_done
//   i_fifo_*             FIFO status and head data; o_fifo_renable pops
//   o_req/o_adrs/o_len   burst command, held until i_ack
//   o_wd_valid/o_wdata/o_wd_last, i_wd_ack   write data stream
//   o_busy               engine not in IDLE
//   o_flush_done         one-cycle pulse once a flush has emptied the FIFO
module fm_cmn_bfifo_burst_rd #(
  parameter int P_WIDTH  = 32,
  parameter int P_RANGE  = 8,
  parameter int P_BURST  = 8,
  parameter int P_ADRS_W = 32
) (
  input  logic                clk_core,
  input  logic                rst_x,
  input  logic                i_start,
  input  logic [P_ADRS_W-1:0] i_adrs_base,
  input  logic                i_enable,
  input  logic                i_flush,
  input  logic                i_fifo_empty,
  input  logic [P_RANGE:0]    i_fifo_dnum,
  input  logic [P_WIDTH-1:0]  i_fifo_dt,
  output logic                o_fifo_renable,
  output logic                o_req,
  output logic [P_ADRS_W-1:0] o_adrs,
  output logic [P_RANGE:0]    o_len,
  input  logic                i_ack,
  output logic                o_wd_valid,
  output logic [P_WIDTH-1:0]  o_wdata,
  output logic                o_wd_last,
  input  logic                i_wd_ack,
  output logic                o_busy,
  output logic                o_flush_done
);

  localparam int CW = P_RANGE + 1;
  localparam logic [CW-1:0] BURST_N = CW'(P_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                state;
  logic [P_ADRS_W-1:0]   adrs;
  logic [CW-1:0]         len;
  logic [CW-1:0]         rem_pop;
  logic [CW-1:0]         rem_ack;
  logic [P_WIDTH-1:0]    wdata_p1;
  logic                  vld_p1;
  logic                  flush_done_p1;
  logic                  flush_seen;

  logic                  launch;
  logic                  load;
  logic                  accept;
  logic                  last_accept;
  logic                  flush_hit;
  logic [CW-1:0]         launch_len;

  // Burst length clamps the fill count to the nominal burst size.
  function automatic logic [CW-1:0] sat_len(input logic [CW-1:0] dnum);
    return (dnum >= BURST_N) ? BURST_N : dnum;
  endfunction

  // i_start has priority over a launch so a new base is never raced.
  assign launch      = (state == IDLE) & i_enable & !i_start &
                       ((i_fifo_dnum >= BURST_N) | (i_flush & (i_fifo_dnum != '0)));
  assign launch_len  = sat_len(i_fifo_dnum);
  assign accept      = vld_p1 & i_wd_ack;
  assign load        = (state == DATA) & (rem_pop != '0) & !i_fifo_empty &
                       (!vld_p1 | i_wd_ack);
  assign last_accept = accept & (rem_ack == CW'(1));
  // flush_seen blocks a second pulse until i_flush is released.
  assign flush_hit   = (state == IDLE) & i_flush & i_fifo_empty & !flush_seen;

  // ---- stage p0: control FSM and burst bookkeeping
  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      state   <= IDLE;
      adrs    <= '0;
      len     <= '0;
      rem_pop <= '0;
      rem_ack <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) adrs <= i_adrs_base;
          if (launch) begin
            len     <= launch_len;
            rem_pop <= launch_len;
            rem_ack <= launch_len;
            state   <= CMD;
          end
        end
        CMD: begin
          if (i_ack) begin
            // Address arithmetic wraps at 2^P_ADRS_W.
            adrs  <= adrs + P_ADRS_W'(len);
            state <= DATA;
          end
        end
        DATA: begin
          if (load)        rem_pop <= rem_pop - CW'(1);
          if (accept)      rem_ack <= rem_ack - CW'(1);
          if (last_accept) state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: registered write-data stage and flush pulse
  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      wdata_p1      <= '0;
      vld_p1        <= 1'b0;
      flush_done_p1 <= 1'b0;
      flush_seen    <= 1'b0;
    end else begin
      if (load) begin
        wdata_p1 <= i_fifo_dt;
        vld_p1   <= 1'b1;
      end else if (accept) begin
        vld_p1   <= 1'b0;
      end
      flush_done_p1 <= flush_hit;
      flush_seen    <= i_flush & (flush_seen | flush_hit);
    end
  end

  assign o_fifo_renable = load;
  assign o_req          = (state == CMD);
  assign o_adrs         = adrs;
  assign o_len          = len;
  assign o_wd_valid     = vld_p1;
  assign o_wdata        = wdata_p1;
  assign o_wd_last      = vld_p1 & (rem_ack == CW'(1));
  assign o_busy         = (state != IDLE);
  assign o_flush_done   = flush_done_p1;

endmodule

// File: tb/tb_fm_cmn_bfifo_burst_rd.sv
// Scoreboard bench for fm_cmn_bfifo_burst_rd: the stimulus pushes expected
// commands and words into queues; a monitor on the falling edge pops and
// compares every accepted command and data word.
module tb_fm_cmn_bfifo_burst_rd;
  localparam int W  = 32;
  localparam int R  = 8;
  localparam int B  = 8;
  localparam int AW = 32;
  localparam int DW = R + 1;

  logic          clk_core = 1'b0;
  logic          rst_x = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_adrs_base = '0;
  logic          i_enable = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_fifo_empty = 1'b1;
  logic [DW-1:0] i_fifo_dnum = '0;
  logic [W-1:0]  i_fifo_dt = '0;
  logic          o_fifo_renable;
  logic          o_req;
  logic [AW-1:0] o_adrs;
  logic [DW-1:0] o_len;
  logic          i_ack = 1'b0;
  logic          o_wd_valid;
  logic [W-1:0]  o_wdata;
  logic          o_wd_last;
  logic          i_wd_ack = 1'b0;
  logic          o_busy;
  logic          o_flush_done;

  always #5 clk_core = ~clk_core;

  fm_cmn_bfifo_burst_rd #(
    .P_WIDTH(W), .P_RANGE(R), .P_BURST(B), .P_ADRS_W(AW)
  ) dut (
    .clk_core(clk_core), .rst_x(rst_x), .i_start(i_start),
    .i_adrs_base(i_adrs_base), .i_enable(i_enable), .i_flush(i_flush),
    .i_fifo_empty(i_fifo_empty), .i_fifo_dnum(i_fifo_dnum),
    .i_fifo_dt(i_fifo_dt), .o_fifo_renable(o_fifo_renable), .o_req(o_req),
    .o_adrs(o_adrs), .o_len(o_len), .i_ack(i_ack), .o_wd_valid(o_wd_valid),
    .o_wdata(o_wdata), .o_wd_last(o_wd_last), .i_wd_ack(i_wd_ack),
    .o_busy(o_busy), .o_flush_done(o_flush_done)
  );

  typedef struct packed {
    logic [AW-1:0] adrs;
    logic [DW-1:0] len;
  } cmd_t;
  typedef struct packed {
    logic [W-1:0] dt;
    logic         last;
  } wd_t;

  logic [W-1:0] fifo_q[$];
  cmd_t         exp_cmd_q[$];
  wd_t          exp_wd_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int req_cycles = 0;
  int pop_cnt = 0;
  int flush_pulses = 0;
  int ack_delay = 0;
  int wd_mode = 0;
  int req_age = 0;
  int pat = 0;
  logic pop_s = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // FIFO model: pop what the DUT requested on the last edge, then present the head.
  always @(posedge clk_core) begin
    #1;
    if (pop_s && fifo_q.size() > 0) fifo_q.delete(0);
    #1;
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_dnum  = DW'(fifo_q.size());
    i_fifo_dt    = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  end

  // Command acknowledge after ack_delay cycles of o_req.
  always @(posedge clk_core) begin
    #1;
    if (o_req) begin
      i_ack = (req_age >= ack_delay);
      req_age++;
    end else begin
      i_ack = 1'b0;
      req_age = 0;
    end
  end

  // Write-data acknowledge: 0 = always, 1 = pattern 1,0,0, 2 = never.
  always @(posedge clk_core) begin
    #1;
    case (wd_mode)
      0:       i_wd_ack = 1'b1;
      1:       begin i_wd_ack = (pat % 3 == 0); pat++; end
      default: i_wd_ack = 1'b0;
    endcase
  end

  // Monitor.
  logic          req_stall = 1'b0;
  logic          wd_stall = 1'b0;
  logic [AW-1:0] prev_adrs = '0;
  logic [DW-1:0] prev_len = '0;
  logic [W-1:0]  prev_wdata = '0;
  logic          prev_last = 1'b0;

  always @(negedge clk_core) begin
    cmd_t c;
    wd_t  e;
    pop_s = o_fifo_renable;
    if (!rst_x) begin
      req_stall = 1'b0;
      wd_stall  = 1'b0;
    end else begin
      if (o_req) req_cycles++;
      if (o_flush_done) flush_pulses++;
      if (o_fifo_renable) begin
        pop_cnt++;
        chk("renable_nonempty", 64'(i_fifo_empty), 64'(0));
        chk("renable_in_data", 64'(o_busy & !o_req), 64'(1));
      end
      if (o_wd_last) chk("last_qualified", 64'(o_wd_valid), 64'(1));
      if (req_stall)
        chk("req_hold", 64'({o_req, o_adrs, o_len}), 64'({1'b1, prev_adrs, prev_len}));
      if (wd_stall)
        chk("wd_hold", 64'({o_wd_valid, o_wd_last, o_wdata}), 64'({1'b1, prev_last, prev_wdata}));
      if (o_req && i_ack) begin
        chk("cmd_expected", 64'(exp_cmd_q.size() != 0), 64'(1));
        if (exp_cmd_q.size() != 0) begin
          c = exp_cmd_q.pop_front();
          chk("cmd_adrs", 64'(o_adrs), 64'(c.adrs));
          chk("cmd_len", 64'(o_len), 64'(c.len));
        end
      end
      if (o_wd_valid && i_wd_ack) begin
        chk("wd_expected", 64'(exp_wd_q.size() != 0), 64'(1));
        if (exp_wd_q.size() != 0) begin
          e = exp_wd_q.pop_front();
          chk("wd_data", 64'(o_wdata), 64'(e.dt));
          chk("wd_last", 64'(o_wd_last), 64'(e.last));
        end
      end
      req_stall  = o_req & !i_ack;
      prev_adrs  = o_adrs;
      prev_len   = o_len;
      wd_stall   = o_wd_valid & !i_wd_ack;
      prev_wdata = o_wdata;
      prev_last  = o_wd_last;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_core);
      #1;
    end
  endtask

  task automatic start(input logic [AW-1:0] a);
    i_adrs_base = a;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic exp_cmd(input logic [AW-1:0] a, input int l);
    cmd_t c;
    c.adrs = a;
    c.len  = DW'(l);
    exp_cmd_q.push_back(c);
  endtask

  // Push n words first, first+1, ... into the FIFO; optionally expect them,
  // with last on every blen-th word and on the final one.
  task automatic push_burst(input logic [W-1:0] first, input int n, input int blen, input bit expect_words);
    wd_t e;
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(first + W'(i));
      e.dt   = first + W'(i);
      e.last = ((i + 1) % blen == 0) || (i == n - 1);
      if (expect_words) exp_wd_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_cmd_q.size() != 0 || exp_wd_q.size() != 0 || o_busy) && t < 400) begin
      tick();
      t++;
    end
    chk(name, 64'(t < 400), 64'(1));
  endtask

  task automatic chk_idle_outputs();
    chk("rst_renable", 64'(o_fifo_renable), 64'(0));
    chk("rst_req", 64'(o_req), 64'(0));
    chk("rst_adrs", 64'(o_adrs), 64'(0));
    chk("rst_len", 64'(o_len), 64'(0));
    chk("rst_wd_valid", 64'(o_wd_valid), 64'(0));
    chk("rst_wdata", 64'(o_wdata), 64'(0));
    chk("rst_wd_last", 64'(o_wd_last), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_flush_done", 64'(o_flush_done), 64'(0));
  endtask

  initial begin
    int snap;
    int t;
    // Reset state
    rst_x = 1'b0;
    tick(3);
    @(negedge clk_core);
    chk_idle_outputs();
    tick();
    rst_x = 1'b1;
    i_enable = 1'b1;
    tick(2);

    // Full burst, then the following burst continues at base+8
    start(32'h100);
    exp_cmd(32'h100, 8);
    pop_cnt = 0;
    push_burst(32'hA0, 8, 8, 1'b1);
    drain("full_burst_done");
    chk("full_burst_pops", 64'(pop_cnt), 64'(8));
    exp_cmd(32'h108, 8);
    push_burst(32'hB0, 8, 8, 1'b1);
    drain("second_burst_done");

    // Threshold hold, then flush releases a 7-word burst
    snap = req_cycles;
    push_burst(32'hC0, 7, 8, 1'b1);
    tick(50);
    chk("hold_no_req", 64'(req_cycles - snap), 64'(0));
    flush_pulses = 0;
    exp_cmd(32'h110, 7);
    i_flush = 1'b1;
    drain("flush_burst_done");
    tick(10);
    chk("flush_done_once", 64'(flush_pulses), 64'(1));
    i_flush = 1'b0;
    tick(2);

    // Backpressure on write data
    wd_mode = 1;
    pop_cnt = 0;
    exp_cmd(32'h117, 8);
    push_burst(32'hD0, 8, 8, 1'b1);
    drain("backpressure_done");
    chk("backpressure_pops", 64'(pop_cnt), 64'(8));
    wd_mode = 0;
    tick(2);

    // Delayed command ack with 20 words: two full bursts, then a flushed 4
    ack_delay = 5;
    exp_cmd(32'h11F, 8);
    exp_cmd(32'h127, 8);
    push_burst(32'hE0, 20, 8, 1'b1);
    t = 0;
    while ((exp_cmd_q.size() != 0 || exp_wd_q.size() > 4 || o_busy) && t < 400) begin
      tick();
      t++;
    end
    chk("delayed_two_bursts", 64'(t < 400), 64'(1));
    snap = req_cycles;
    tick(30);
    chk("remainder_held", 64'(req_cycles - snap), 64'(0));
    exp_cmd(32'h12F, 4);
    i_flush = 1'b1;
    drain("remainder_flush_done");
    i_flush = 1'b0;
    ack_delay = 0;
    tick(2);

    // Address wrap at 2^32
    start(32'hFFFF_FFFC);
    exp_cmd(32'hFFFF_FFFC, 8);
    exp_cmd(32'h0000_0004, 8);
    push_burst(32'h5000, 16, 8, 1'b1);
    drain("wrap_done");

    // Reset in the middle of DATA
    wd_mode = 2;
    start(32'h200);
    exp_cmd(32'h200, 8);
    push_burst(32'h600, 8, 8, 1'b0);
    t = 0;
    while (!o_wd_valid && t < 50) begin
      tick();
      t++;
    end
    chk("reached_data", 64'(o_wd_valid), 64'(1));
    rst_x = 1'b0;
    @(negedge clk_core);
    chk_idle_outputs();
    tick();
    fifo_q.delete();
    exp_cmd_q.delete();
    wd_mode = 0;
    tick();
    rst_x = 1'b1;
    tick(2);

    // After reset the address register restarts at 0
    exp_cmd(32'h0, 8);
    push_burst(32'h700, 8, 8, 1'b1);
    drain("post_reset_done");

    tick(5);
    chk("cmd_queue_empty", 64'(exp_cmd_q.size()), 64'(0));
    chk("wd_queue_empty", 64'(exp_wd_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/fm_cmn_bfifo_burst_rd.md
# fm_cmn_bfifo_burst_rd

Burst drain engine for the consumer end of a block-RAM FIFO. It watches the FIFO fill count and waits until a full burst is buffered, or a flush requests a partial one. It then issues one write-burst command on the memory request bus and streams exactly that many words from the FIFO head through a registered data stage. It sits between a first-word-fall-through FIFO (head data valid combinationally whenever non-empty; asserting read-enable pops it) and a memory-side arbiter port.

## Interface
Parameters:
- P_WIDTH, 32, data word width
- P_RANGE, 8, FIFO address bits; fill count is P_RANGE+1 bits
- P_BURST, 8, nominal burst length in words; legal range 1 to 2^P_RANGE
- P_ADRS_W, 32, word address width

Ports:
- clk_core  in  1  system clock
- rst_x  in  1  asynchronous active-low reset
- i_start  in  1  pulse; loads base address; honoured only in IDLE
- i_adrs_base  in  P_ADRS_W  word address loaded by i_start
- i_enable  in  1  permits new bursts; does not abort a burst in progress
- i_flush  in  1  level; permits a partial burst (1..P_BURST-1 words)
- i_fifo_empty  in  1  FIFO empty
- i_fifo_dnum  in  P_RANGE+1  FIFO fill count
- i_fifo_dt  in  P_WIDTH  FIFO head data
- o_fifo_renable  out  1  pop FIFO head this cycle
- o_req  out  1  burst command request
- o_adrs  out  P_ADRS_W  burst start word address
- o_len  out  P_RANGE+1  burst length in words, 1..P_BURST
- i_ack  in  1  command accepted
- o_wd_valid  out  1  write data valid
- o_wdata  out  P_WIDTH  write data
- o_wd_last  out  1  marks the final word of the burst
- i_wd_ack  in  1  write data accepted
- o_busy  out  1  state is not IDLE
- o_flush_done  out  1  one-cycle pulse: flush complete

## Operation
- Reset: state IDLE. r_adrs=0, r_len=0, both remaining counters=0. All outputs are 0.
- IDLE:
  - i_start loads r_adrs<=i_adrs_base.
  - Launch condition: i_enable & !i_start & (dnum>=P_BURST | (i_flush & dnum!=0)).
  - On launch: r_len<=min(dnum,P_BURST); r_rem_pop<=r_len; r_rem_ack<=r_len; go to CMD.
- CMD:
  - o_req=1, with o_adrs=r_adrs and o_len=r_len held stable until i_ack.
  - On i_ack: r_adrs<=r_adrs+r_len, modulo 2^P_ADRS_W; go to DATA.
- DATA:
  - Load condition w_load = (r_rem_pop!=0) & !i_fifo_empty & (!o_wd_valid | i_wd_ack).
  - o_fifo_renable=w_load. It never asserts outside DATA and never when the FIFO is empty.
  - On w_load: o_wdata<=i_fifo_dt; o_wd_valid<=1; r_rem_pop decrements.
  - On a word acceptance without a load (o_wd_valid & i_wd_ack & !w_load): o_wd_valid<=0.
  - Each acceptance decrements r_rem_ack.
  - o_wd_last=o_wd_valid & (r_rem_ack==1).
  - When the last word is accepted, go to IDLE; o_wd_valid clears the same edge.
- This block is the FIFO's sole consumer, so words counted at launch remain available. Concurrent FIFO writes only add words.
- o_flush_done: a one-cycle pulse when in IDLE, i_flush=1, i_fifo_empty=1, and the previous cycle was not already pulsing. It re-arms when i_flush drops.
- Deasserting i_enable or i_flush mid-burst has no effect until the return to IDLE.
- Reset mid-burst returns to the reset state immediately. The partial burst is lost; the FIFO contents are not reset by this block.

## Timing
- Launch is registered: o_req rises the cycle after the launch condition is true.
- The earliest i_ack is in the same cycle as o_req. DATA is entered the next edge.
- First o_wd_valid: 1 cycle after entering DATA, if the FIFO is non-empty.
- Back-to-back: with i_wd_ack held at 1, one word transfers per cycle with no bubbles.
- Minimum gap from final word acceptance to next o_req: 1 IDLE cycle, then the launch edge (2 cycles).
- o_wdata, o_wd_valid and o_wd_last hold stable while o_wd_valid=1 & i_wd_ack=0.

## Test plan
- Reset, then check idle outputs: assert rst_x low mid-DATA → all outputs 0 next cycle; state IDLE, o_busy=0.
- Full burst: base=0x100, 8 words 0xA0..0xA7 pushed, i_ack immediate, i_wd_ack=1 → o_req with o_adrs=0x100 and o_len=8; 8 consecutive words with o_wd_last on 0xA7; next burst o_adrs=0x108.
- Threshold hold: 7 words, i_flush=0 → no o_req for 50 cycles. Raise i_flush → burst with o_len=7, then o_flush_done pulses once after the FIFO empties.
- Backpressure: i_wd_ack toggles 1,0,0,1… → o_wdata is held during stalls; each word is delivered exactly once and in order; o_fifo_renable count = 8.
- Delayed i_ack (5 cycles) with 20 words buffered → o_adrs and o_len stable throughout; o_fifo_renable stays 0 until DATA; two 8-word bursts follow, then nothing until flush (4 left, o_len=4).
- Address wrap: P_ADRS_W=8, base=0xFC, burst 8 → o_adrs=0xFC, next burst o_adrs=0x04.
